// File: rtl/gs232c_rr_arbiter_pkg.sv
// Shared types and default sizing for the gs232c round-robin arbiter.
package gs232c_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_N     = 4;
  localparam int DEF_TMO_W = 4;

endpackage

// File: rtl/gs232c_arb_pick.sv
// Lowest-set-bit picker: every bit above the first set bit is masked off.
module gs232c_arb_pick
  import gs232c_rr_arbiter_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] pick,
  output logic         any
);

  logic seen_s;

  // walk upward; once a set bit has been seen, mask every higher bit
  always_comb begin
    pick   = '0;
    seen_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      pick[i] = vec[i] & ~seen_s;
      seen_s  = seen_s | vec[i];
    end
    any = seen_s;
  end

endmodule

// File: rtl/gs232c_rr_arbiter.sv
// Round-robin arbiter with grant hold until done/abort; optional hold timeout
// compiled in with GS232C_ARB_TIMEOUT_EN (adds the tmo port).
module gs232c_rr_arbiter
  import gs232c_rr_arbiter_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int TMO_W = DEF_TMO_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 busy
`ifdef GS232C_ARB_TIMEOUT_EN
  ,
  output logic                 tmo
`endif
);

  localparam int PW = $clog2(N);

  arb_state_e    state_r, state_nxt_s;
  logic [PW-1:0] ptr_r, ptr_nxt_s;
  logic [PW-1:0] gnt_idx_r, idx_nxt_s;
  logic [N-1:0]  gnt_r, gnt_nxt_s;
  logic          busy_r, busy_nxt_s;

  logic [PW-1:0] rel_ptr_s, cand_ptr_s;
  logic [N-1:0]  cand_req_s, hi_s, hi_pick_s, req_pick_s, win_s;
  logic          hi_any_s, req_any_s, owner_req_s, release_s, tmo_hit_s;

  function automatic logic [PW-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | PW'(i);
      else       idx = idx;
    end
    return idx;
  endfunction

`ifdef GS232C_ARB_TIMEOUT_EN
  // release fires on the cycle the hold counter would step onto all-ones
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  logic [TMO_W-1:0] cnt_r, cnt_nxt_s;

  assign tmo_hit_s = (state_r == ST_GRANT) && (cnt_r == TMO_LAST);
  assign tmo       = tmo_hit_s & ~done;
`else
  assign tmo_hit_s = 1'b0;
`endif

  assign owner_req_s = |(req & gnt_r);
  assign release_s   = (state_r == ST_GRANT) & (done | ~owner_req_s | tmo_hit_s);
  assign rel_ptr_s   = (gnt_idx_r == PW'(N - 1)) ? '0 : gnt_idx_r + PW'(1);

  // on a release the outgoing owner is masked and priority starts just after it
  always_comb begin
    cand_req_s = req;
    cand_ptr_s = ptr_r;
    hi_s       = '0;
    if (release_s) begin
      cand_req_s = req & ~gnt_r;
      cand_ptr_s = rel_ptr_s;
    end else begin
      cand_req_s = req;
      cand_ptr_s = ptr_r;
    end
    for (int i = 0; i < N; i++) begin
      hi_s[i] = cand_req_s[i] & (PW'(i) >= cand_ptr_s);
    end
  end

  gs232c_arb_pick #(.N(N)) u_pick_hi (
    .vec  (hi_s),
    .pick (hi_pick_s),
    .any  (hi_any_s)
  );

  gs232c_arb_pick #(.N(N)) u_pick_req (
    .vec  (cand_req_s),
    .pick (req_pick_s),
    .any  (req_any_s)
  );

  assign win_s = hi_any_s ? hi_pick_s : req_pick_s;

  // next-state and next-output decode
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    idx_nxt_s   = gnt_idx_r;
    busy_nxt_s  = busy_r;
    ptr_nxt_s   = ptr_r;
`ifdef GS232C_ARB_TIMEOUT_EN
    cnt_nxt_s   = cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (req_any_s) begin
          state_nxt_s = ST_GRANT;
          gnt_nxt_s   = win_s;
          idx_nxt_s   = onehot_to_idx(win_s);
          busy_nxt_s  = 1'b1;
`ifdef GS232C_ARB_TIMEOUT_EN
          cnt_nxt_s   = '0;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = '0;
          idx_nxt_s   = '0;
          busy_nxt_s  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          ptr_nxt_s = rel_ptr_s;
          if (req_any_s) begin
            state_nxt_s = ST_GRANT;
            gnt_nxt_s   = win_s;
            idx_nxt_s   = onehot_to_idx(win_s);
            busy_nxt_s  = 1'b1;
`ifdef GS232C_ARB_TIMEOUT_EN
            cnt_nxt_s   = '0;
`endif
          end else begin
            state_nxt_s = ST_IDLE;
            gnt_nxt_s   = '0;
            idx_nxt_s   = '0;
            busy_nxt_s  = 1'b0;
          end
        end else begin
          state_nxt_s = ST_GRANT;
`ifdef GS232C_ARB_TIMEOUT_EN
          cnt_nxt_s   = cnt_r + TMO_W'(1);
`endif
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = '0;
        idx_nxt_s   = '0;
        busy_nxt_s  = 1'b0;
        ptr_nxt_s   = '0;
      end
    endcase
  end

  // state, pointer and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      gnt_r     <= '0;
      gnt_idx_r <= '0;
      busy_r    <= 1'b0;
`ifdef GS232C_ARB_TIMEOUT_EN
      cnt_r     <= '0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      gnt_r     <= gnt_nxt_s;
      gnt_idx_r <= idx_nxt_s;
      busy_r    <= busy_nxt_s;
`ifdef GS232C_ARB_TIMEOUT_EN
      cnt_r     <= cnt_nxt_s;
`endif
    end
  end

  assign gnt     = gnt_r;
  assign gnt_idx = gnt_idx_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_gs232c_rr_arbiter.sv
// Scoreboard bench for gs232c_rr_arbiter (N=4); timeout vectors run when
// GS232C_ARB_TIMEOUT_EN is defined.
module tb_gs232c_rr_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       done = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
`ifdef GS232C_ARB_TIMEOUT_EN
  logic       tmo;
`endif

  always #5 clk = ~clk;

  gs232c_rr_arbiter #(.N(4), .TMO_W(4)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy)
`ifdef GS232C_ARB_TIMEOUT_EN
    ,
    .tmo     (tmo)
`endif
  );

  typedef struct {
    logic [3:0] g;
    logic [1:0] i;
    logic       b;
    logic       t;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic tmo_pre;

  // monitor: tmo is sampled mid-cycle with inputs applied, gnt/idx/busy after the edge
  always begin
    @(negedge clk);
    #2;
`ifdef GS232C_ARB_TIMEOUT_EN
    tmo_pre = tmo;
`else
    tmo_pre = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (gnt !== e.g || gnt_idx !== e.i || busy !== e.b || tmo_pre !== e.t) begin
        bad++;
        $display("FAIL %s: got gnt=%b idx=%0d busy=%b tmo=%b, want gnt=%b idx=%0d busy=%b tmo=%b",
                 e.nm, gnt, gnt_idx, busy, tmo_pre, e.g, e.i, e.b, e.t);
      end
    end
  end

  task automatic cyc(input logic [3:0] r, input logic d, input logic [3:0] g,
                     input int i, input logic b, input logic t, input string nm);
    exp_t x;
    @(negedge clk);
    req  = r;
    done = d;
    x.g  = g;
    x.i  = 2'(i);
    x.b  = b;
    x.t  = t;
    x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic chk_idle_now(input string nm);
    logic t;
`ifdef GS232C_ARB_TIMEOUT_EN
    t = tmo;
`else
    t = 1'b0;
`endif
    total++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || busy !== 1'b0 || t !== 1'b0) begin
      bad++;
      $display("FAIL %s: got gnt=%b idx=%0d busy=%b tmo=%b, want all zero", nm, gnt, gnt_idx, busy, t);
    end
  endtask

  initial begin
    #12;
    chk_idle_now("reset_state");
    @(negedge clk);
    resetn = 1'b1;

    // basic grant, done hand-over, ptr wrap to 0 through an idle release
    cyc(4'b0101, 1'b0, 4'b0001, 0, 1'b1, 1'b0, "a_first");
    cyc(4'b0101, 1'b1, 4'b0100, 2, 1'b1, 1'b0, "a_done_next");
    cyc(4'b0101, 1'b0, 4'b0100, 2, 1'b1, 1'b0, "a_hold");
    cyc(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 1'b0, "a_idle");
    cyc(4'b1000, 1'b0, 4'b1000, 3, 1'b1, 1'b0, "a_own3");
    cyc(4'b1000, 1'b1, 4'b0000, 0, 1'b0, 1'b0, "a_rel3_idle");

    // all requesting, done every second cycle: 0,1,2,3,0 without bubbles
    cyc(4'b1111, 1'b0, 4'b0001, 0, 1'b1, 1'b0, "b_g0");
    cyc(4'b1111, 1'b1, 4'b0010, 1, 1'b1, 1'b0, "b_g1");
    cyc(4'b1111, 1'b0, 4'b0010, 1, 1'b1, 1'b0, "b_h1");
    cyc(4'b1111, 1'b1, 4'b0100, 2, 1'b1, 1'b0, "b_g2");
    cyc(4'b1111, 1'b0, 4'b0100, 2, 1'b1, 1'b0, "b_h2");
    cyc(4'b1111, 1'b1, 4'b1000, 3, 1'b1, 1'b0, "b_g3");
    cyc(4'b1111, 1'b0, 4'b1000, 3, 1'b1, 1'b0, "b_h3");
    cyc(4'b1111, 1'b1, 4'b0001, 0, 1'b1, 1'b0, "b_wrap0");
    cyc(4'b0000, 1'b0, 4'b0000, 0, 1'b0, 1'b0, "b_abort_idle");

    // owner 3 wraps ptr to 0, then owner 1 aborts
    cyc(4'b1001, 1'b0, 4'b1000, 3, 1'b1, 1'b0, "c_own3");
    cyc(4'b1001, 1'b1, 4'b0001, 0, 1'b1, 1'b0, "c_wrap");
    cyc(4'b0011, 1'b1, 4'b0010, 1, 1'b1, 1'b0, "c_to1");
    cyc(4'b0000, 1'b0, 4'b0000, 0, 1'b0, 1'b0, "d_abort_idle");
    cyc(4'b0111, 1'b0, 4'b0100, 2, 1'b1, 1'b0, "d_ptr2");
    cyc(4'b1111, 1'b0, 4'b0100, 2, 1'b1, 1'b0, "d_hold_others");
    cyc(4'b0100, 1'b1, 4'b0000, 0, 1'b0, 1'b0, "d_self_masked");
    cyc(4'b0100, 1'b0, 4'b0100, 2, 1'b1, 1'b0, "d_regain");
    cyc(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 1'b0, "d_done_abort");
    cyc(4'b0001, 1'b0, 4'b0001, 0, 1'b1, 1'b0, "e_grant0");

    // asynchronous reset in the middle of a grant (ptr was 3)
    @(posedge clk);
    #3;
    resetn = 1'b0;
    req    = 4'b0000;
    done   = 1'b0;
    #1;
    chk_idle_now("e_async_reset");
    @(negedge clk);
    resetn = 1'b1;
    cyc(4'b1001, 1'b0, 4'b0001, 0, 1'b1, 1'b0, "e_ptr0");
    cyc(4'b1000, 1'b1, 4'b1000, 3, 1'b1, 1'b0, "e_to3");
    cyc(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 1'b0, "e_idle");

`ifdef GS232C_ARB_TIMEOUT_EN
    // forced release on the 15th grant cycle, then done on the terminal cycle
    cyc(4'b0001, 1'b0, 4'b0001, 0, 1'b1, 1'b0, "t_grant");
    for (int k = 1; k <= 14; k++) cyc(4'b0011, 1'b0, 4'b0001, 0, 1'b1, 1'b0, "t_hold0");
    cyc(4'b0011, 1'b0, 4'b0010, 1, 1'b1, 1'b1, "t_tmo");
    for (int k = 1; k <= 14; k++) cyc(4'b0011, 1'b0, 4'b0010, 1, 1'b1, 1'b0, "t_hold1");
    cyc(4'b0011, 1'b1, 4'b0001, 0, 1'b1, 1'b0, "t_done_tc");
    cyc(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 1'b0, "t_idle");
`else
    // without the timeout a grant is held indefinitely
    cyc(4'b0001, 1'b0, 4'b0001, 0, 1'b1, 1'b0, "n_grant");
    for (int k = 1; k <= 20; k++) cyc(4'b0011, 1'b0, 4'b0001, 0, 1'b1, 1'b0, "n_hold");
    cyc(4'b0000, 1'b1, 4'b0000, 0, 1'b0, 1'b0, "n_idle");
`endif

    @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
